key_expander: RTL
=================

KEY_EXPANDER -- requirements
Module: key_expander

Interface
REQ-001 SHALL have parameter NR, default 10, meaning number of AES-128 rounds; only 10 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request expansion of key_in; sampled only while busy=0.
REQ-005 SHALL have port key_in  input  128  cipher key; [127:96]=w0 … [31:0]=w3 (FIPS-197 byte order, MSB first).
REQ-006 SHALL have port busy  output  1  high while an expansion is in progress.
REQ-007 SHALL have port rk_valid  output  1  rk_out/rk_idx hold a valid round key this cycle.
REQ-008 SHALL have port rk_idx  output  4  round number of rk_out, 0..10.
REQ-009 SHALL have port rk_out  output  128  round key, same word order as key_in.
REQ-010 SHALL have port done  output  1  one-cycle pulse coincident with round key 10.

Function
REQ-011 SHALL implement FSM states IDLE and RUN; IDLE->RUN on start=1; RUN->IDLE after emitting rk_idx=10.
REQ-012 SHALL, on start accepted in IDLE at cycle T, latch key_in into key_reg and clear round counter to 0.
REQ-013 SHALL in RUN drive rk_valid=1, rk_out=key_reg, rk_idx=round every cycle: rk0 at T+1, rk_n at T+1+n, rk10 at T+11.
REQ-014 SHALL hold busy=1 from T+1 through T+11 inclusive, 0 otherwise.
REQ-015 SHALL assert done=1 only at T+11 (rk_idx=10), with busy=1 in that same cycle.
REQ-016 SHALL compute the next key per cycle as temp=SubWord(RotWord(w3)) XOR {Rcon[round+1],24'h0}; w0'=w0^temp; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
REQ-017 SHALL define RotWord as the 1-byte left rotation {w3[23:0],w3[31:24]}.
REQ-018 SHALL use Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36 (hex).
REQ-019 SHALL ignore start while busy=1, including the done cycle; a new start is accepted no earlier than T+12.
REQ-020 SHALL sample key_in only in the accept cycle; later key_in changes SHALL NOT affect the running expansion.
REQ-021 SHALL drive rk_valid=0, done=0 in IDLE; rk_out and rk_idx hold their last values there.
REQ-022 SHALL accept back-to-back starts (start held high) with one idle cycle between expansions.
REQ-023 SHALL wrap nothing: round counter stops at 10 and returns to 0 only on the next accept.

Reset
REQ-024 SHALL on reset=1 at a clock edge force state=IDLE, round=0, key_reg=0, busy=0, rk_valid=0, done=0, rk_idx=0, rk_out=0.
REQ-025 SHALL treat reset as dominant over start in the same cycle; reset mid-RUN aborts with no done pulse.

Structure
REQ-026 SHALL take the Rcon table, FSM state encoding and the 128-bit key width from the shared AES package aes_pkg.
REQ-027 SHALL instantiate exactly one existing SubWord sub-module, fed with RotWord(w3) of key_reg; no local S-box copy.
REQ-028 SHALL register all outputs; the only combinational path is key_reg -> SubWord -> XOR -> key_reg.

Verification
REQ-029 SHALL cover FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c -> rk1=a0fafe1788542cb123a339392a6c7605, rk10=d014f9a8c9ee2589e13f0cc8b6630ca6 at T+11 with done=1.
REQ-030 SHALL cover key all-zeros -> rk1=62636363626363636263636362636363, rk10=b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-031 SHALL cover start pulsed at T+5 with a different key_in -> ignored; rk10 still matches the first key, exactly one done.
REQ-032 SHALL cover reset asserted at T+4 -> next cycle busy=0, rk_valid=0, rk_out=0, no done; a fresh start then yields the correct rk0..rk10.
REQ-033 SHALL cover start held high for 30 cycles -> two full expansions, done pulses at T+11 and T+23, rk_valid low at T+12.
REQ-034 SHALL cover key_in changed every cycle during RUN -> all eleven round keys unchanged versus the latched-key golden model.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, key-expander FSM states and the round-constant table.
package aes_pkg;

   localparam int unsigned KEY_W  = 128;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned RND_W  = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Rcon[i] for i = 1..10; any other index yields zero.
   function automatic logic [7:0] rcon(input logic [RND_W-1:0] i_idx);
      logic [7:0] v;
      case (i_idx)
         4'd1:    v = 8'h01;
         4'd2:    v = 8'h02;
         4'd3:    v = 8'h04;
         4'd4:    v = 8'h08;
         4'd5:    v = 8'h10;
         4'd6:    v = 8'h20;
         4'd7:    v = 8'h40;
         4'd8:    v = 8'h80;
         4'd9:    v = 8'h1b;
         4'd10:   v = 8'h36;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/key_expander_subword.sv
// SubWord: applies the AES S-box independently to each byte of a 32-bit word.
module key_expander_subword
   import aes_pkg::*;
(
   input  logic [WORD_W-1:0] i_word,
   output logic [WORD_W-1:0] o_word
);

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   // Byte-wise S-box lookup.
   always_comb begin
      o_word = '0;
      for (int unsigned b = 0; b < 4; b++) begin
         o_word[8*b +: 8] = SBOX[i_word[8*b +: 8]];
      end
   end

endmodule

// File: rtl/key_expander.sv
// AES-128 key expander: emits round keys 0..NR, one per cycle, after a start request.
module key_expander
   import aes_pkg::*;
#(
   parameter int unsigned NR = 10
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [KEY_W-1:0] key_in,
   output logic             busy,
   output logic             rk_valid,
   output logic [RND_W-1:0] rk_idx,
   output logic [KEY_W-1:0] rk_out,
   output logic             done
);

   localparam logic [RND_W-1:0] LAST = RND_W'(NR);

   state_t             r_state;
   state_t             w_state_nxt;
   logic               w_accept;
   logic [KEY_W-1:0]   r_key;
   logic [RND_W-1:0]   r_round;
   logic               r_busy;
   logic               r_done;

   logic [WORD_W-1:0]  w_rot;
   logic [WORD_W-1:0]  w_sub;
   logic [WORD_W-1:0]  w_temp;
   logic [WORD_W-1:0]  w_n0, w_n1, w_n2, w_n3;

   // Key-schedule core: one round key derived from the current one.
   assign w_rot  = {r_key[23:0], r_key[31:24]};

   key_expander_subword u_subword (
      .i_word (w_rot),
      .o_word (w_sub)
   );

   assign w_temp = w_sub ^ {rcon(r_round + 4'd1), 24'h000000};
   assign w_n0   = r_key[127:96] ^ w_temp;
   assign w_n1   = r_key[95:64]  ^ w_n0;
   assign w_n2   = r_key[63:32]  ^ w_n1;
   assign w_n3   = r_key[31:0]   ^ w_n2;

   // Next-state logic: accept start only in IDLE, leave RUN after the last round key.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_RUN;
               w_accept    = 1'b1;
            end
         end
         ST_RUN: begin
            if (r_round == LAST) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Key/round registers double as the rk_out/rk_idx outputs; busy and done are
   // registered from the next state so every output comes straight from a flop.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_key   <= '0;
         r_round <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_key   <= key_in;
            r_round <= '0;
         end else if (r_state == ST_RUN && r_round != LAST) begin
            r_key   <= {w_n0, w_n1, w_n2, w_n3};
            r_round <= r_round + 4'd1;
         end
         r_busy <= (w_state_nxt == ST_RUN);
         r_done <= (r_state == ST_RUN) && (r_round == LAST - 4'd1);
      end
   end

   assign busy     = r_busy;
   assign rk_valid = r_busy;
   assign rk_idx   = r_round;
   assign rk_out   = r_key;
   assign done     = r_done;

endmodule
